// File: rtl/turn_scheduler.sv
// Battleship turn controller: alternates the fire resource between two players,
// sequences the shared turn timer, tallies hits and declares a winner.
module turn_scheduler #(
    parameter int TURN_TICKS = 15,
    parameter int WIN_HITS   = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tick,
    input  logic       fire_p0,
    input  logic       fire_p1,
    input  logic       hit_valid,
    input  logic       hit,
    input  logic [3:0] cnt_val,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       player,
    output logic       fire_grant,
    output logic       timeout,
    output logic [4:0] score0,
    output logic [4:0] score1,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {IDLE, TURN, RESOLVE, SWAP, DONE} state_t;

    localparam logic [3:0] TICKS_LIM = 4'(TURN_TICKS);
    localparam logic [4:0] WIN_LIM   = 5'(WIN_HITS);

    state_t          state, state_n;
    logic            player_n, clr_n, grant_n, tout_n, winner_n;
    logic [1:0][4:0] score, score_n;
    logic            fire_act;
    logic [4:0]      score_inc;

    assign fire_act  = player ? fire_p1 : fire_p0;
    assign score_inc = score[player] + 5'd1;
    // Timer freezes outside TURN and on the clear cycle itself.
    assign cnt_en    = (state == TURN) & tick & ~cnt_clr;
    assign score0    = score[0];
    assign score1    = score[1];
    assign game_over = (state == DONE);

    always_comb begin
        state_n  = state;
        player_n = player;
        score_n  = score;
        clr_n    = 1'b0;
        grant_n  = 1'b0;
        tout_n   = 1'b0;
        winner_n = winner;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n  = TURN;
                    player_n = 1'b0;
                    score_n  = '0;
                    clr_n    = 1'b1;
                end
            end
            TURN: begin
                // Counter value is stale during the clear cycle, so skip it.
                if (!cnt_clr) begin
                    if (fire_act) begin
                        grant_n = 1'b1;
                        state_n = RESOLVE;
                    end else if (cnt_val >= TICKS_LIM) begin
                        tout_n  = 1'b1;
                        state_n = SWAP;
                    end
                end
            end
            RESOLVE: begin
                if (hit_valid) begin
                    state_n = SWAP;
                    if (hit) begin
                        score_n[player] = score_inc;
                        if (score_inc == WIN_LIM) begin
                            state_n  = DONE;
                            winner_n = player;
                        end
                    end
                end
            end
            SWAP: begin
                player_n = ~player;
                clr_n    = 1'b1;
                state_n  = TURN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            player     <= 1'b0;
            score      <= '0;
            cnt_clr    <= 1'b0;
            fire_grant <= 1'b0;
            timeout    <= 1'b0;
            winner     <= 1'b0;
        end else begin
            state      <= state_n;
            player     <= player_n;
            score      <= score_n;
            cnt_clr    <= clr_n;
            fire_grant <= grant_n;
            timeout    <= tout_n;
            winner     <= winner_n;
        end
    end

endmodule

// File: tb/tb_turn_scheduler.sv
// Scoreboard bench for turn_scheduler: stimulus queues expected pulse events,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_turn_scheduler;

    logic       clk = 1'b0;
    logic       rst, start, tick, fire_p0, fire_p1, hit_valid, hit;
    logic [3:0] cnt_val;
    logic       cnt_clr, cnt_en, player, fire_grant, timeout, game_over, winner;
    logic [4:0] score0, score1;

    localparam logic [1:0] K_CLR = 2'd0, K_GRANT = 2'd1, K_TOUT = 2'd2, K_OVER = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic       pl;
        logic [4:0] s0;
        logic [4:0] s1;
        logic       w;
    } ev_t;

    ev_t  q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    bit   tick_on = 1'b0;
    int   tcnt = 0;
    logic go_prev = 1'b0;

    turn_scheduler #(.TURN_TICKS(15), .WIN_HITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick),
        .fire_p0(fire_p0), .fire_p1(fire_p1), .hit_valid(hit_valid), .hit(hit),
        .cnt_val(cnt_val), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .player(player),
        .fire_grant(fire_grant), .timeout(timeout), .score0(score0), .score1(score1),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    // Turn-timer counter model driven by the DUT's clear/enable.
    always @(posedge clk or posedge rst) begin
        if (rst)          cnt_val <= 4'd0;
        else if (cnt_clr) cnt_val <= 4'd0;
        else if (cnt_en)  cnt_val <= cnt_val + 4'd1;
    end

    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick = tick_on && (tcnt % 4 == 3);
            tcnt++;
        end
    end

    function automatic ev_t mk(logic [1:0] k, logic p, logic [4:0] a, logic [4:0] b, logic w);
        ev_t e;
        e.kind = k; e.pl = p; e.s0 = a; e.s1 = b; e.w = w;
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Monitor: every output pulse (or game_over rising) must match the queue head.
    initial begin
        ev_t a, e;
        forever begin
            @(negedge clk);
            if (cnt_clr || fire_grant || timeout || (game_over && !go_prev)) begin
                a.kind = cnt_clr ? K_CLR : fire_grant ? K_GRANT : timeout ? K_TOUT : K_OVER;
                a.pl = player; a.s0 = score0; a.s1 = score1;
                a.w  = (a.kind == K_OVER) ? winner : 1'b0;
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_event: got kind=%0d pl=%0d s0=%0d s1=%0d w=%0d expected none",
                             a.kind, a.pl, a.s0, a.s1, a.w);
                end else begin
                    e = q.pop_front();
                    if (a == e) n_pass++;
                    else $display("FAIL event: got kind=%0d pl=%0d s0=%0d s1=%0d w=%0d expected kind=%0d pl=%0d s0=%0d s1=%0d w=%0d",
                                  a.kind, a.pl, a.s0, a.s1, a.w, e.kind, e.pl, e.s0, e.s1, e.w);
                end
            end
            go_prev = game_over;
        end
    end

    task automatic wait_drain(string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_chk++;
        if (ok) n_pass++;
        else begin
            $display("FAIL drain_%s: got %0d pending events expected 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic shoot(bit p, int hold);
        bit found = 1'b0;
        if (p) fire_p1 = 1'b1; else fire_p0 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fire_grant) begin found = 1'b1; break; end
        end
        n_chk++;
        if (found) n_pass++;
        else $display("FAIL grant_wait: got no grant expected grant for player %0d", p);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("resolve_cnt_en", {31'd0, cnt_en}, 32'd0);
        end
        @(posedge clk); #1;
        fire_p0 = 1'b0; fire_p1 = 1'b0;
    endtask

    task automatic hitres(bit h);
        @(posedge clk); #1;
        hit_valid = 1'b1; hit = h;
        @(posedge clk); #1;
        hit_valid = 1'b0; hit = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        bit reached;
        rst = 1'b1; start = 1'b0; fire_p0 = 1'b0; fire_p1 = 1'b0;
        hit_valid = 1'b0; hit = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_player", {31'd0, player}, 32'd0);
        chk("rst_score0", {27'd0, score0}, 32'd0);
        chk("rst_score1", {27'd0, score1}, 32'd0);
        chk("rst_cnt_clr", {31'd0, cnt_clr}, 32'd0);
        chk("rst_game_over", {31'd0, game_over}, 32'd0);
        chk("rst_grant_tout", {30'd0, fire_grant, timeout}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        tick_on = 1'b1;

        // Start: clear pulse, player 0, scores 0; then cnt_en tracks tick.
        q.push_back(mk(K_CLR, 1'b0, 5'd0, 5'd0, 1'b0));
        pulse_start();
        wait_drain("start");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("cnt_en_tick", {31'd0, cnt_en}, {31'd0, tick});
        end

        // Inactive player's fire is ignored.
        @(posedge clk); #1 fire_p1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("p1_fire_ignored", {31'd0, fire_grant}, 32'd0);
        end
        @(posedge clk); #1 fire_p1 = 1'b0;

        // Held fire, one grant only; hit scores and passes the turn.
        q.push_back(mk(K_GRANT, 1'b0, 5'd0, 5'd0, 1'b0));
        shoot(1'b0, 5);
        q.push_back(mk(K_CLR, 1'b1, 5'd1, 5'd0, 1'b0));
        hitres(1'b1);
        wait_drain("hit_p0");

        // Player 1 idles until the timer reaches 15.
        q.push_back(mk(K_TOUT, 1'b1, 5'd1, 5'd0, 1'b0));
        q.push_back(mk(K_CLR, 1'b0, 5'd1, 5'd0, 1'b0));
        wait_drain("timeout");

        // Fire in the very cycle the count hits 15: fire wins.
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (cnt_val == 4'd15) begin reached = 1'b1; break; end
        end
        chk("cnt_reach_15", {31'd0, reached}, 32'd1);
        q.push_back(mk(K_GRANT, 1'b0, 5'd1, 5'd0, 1'b0));
        shoot(1'b0, 1);
        q.push_back(mk(K_CLR, 1'b1, 5'd2, 5'd0, 1'b0));
        hitres(1'b1);
        wait_drain("fire_vs_timeout");

        // start mid-TURN is ignored.
        pulse_start();
        repeat (2) @(negedge clk);
        chk("midturn_start_player", {31'd0, player}, 32'd1);
        chk("midturn_start_score0", {27'd0, score0}, 32'd2);

        // Player 1 misses.
        q.push_back(mk(K_GRANT, 1'b1, 5'd2, 5'd0, 1'b0));
        shoot(1'b1, 2);
        q.push_back(mk(K_CLR, 1'b0, 5'd2, 5'd0, 1'b0));
        hitres(1'b0);
        wait_drain("miss_p1");

        // hit_valid outside RESOLVE is ignored.
        hitres(1'b1);
        @(negedge clk);
        chk("stray_hit_score0", {27'd0, score0}, 32'd2);

        // Third hit by player 0 wins.
        q.push_back(mk(K_GRANT, 1'b0, 5'd2, 5'd0, 1'b0));
        shoot(1'b0, 1);
        q.push_back(mk(K_OVER, 1'b0, 5'd3, 5'd0, 1'b0));
        hitres(1'b1);
        wait_drain("win");
        @(negedge clk);
        chk("done_game_over", {31'd0, game_over}, 32'd1);

        // Fire in DONE is ignored.
        @(posedge clk); #1 fire_p0 = 1'b1; fire_p1 = 1'b1;
        repeat (5) @(posedge clk);
        #1 fire_p0 = 1'b0; fire_p1 = 1'b0;
        @(negedge clk);
        chk("done_score0_held", {27'd0, score0}, 32'd3);

        // Restart from DONE.
        q.push_back(mk(K_CLR, 1'b0, 5'd0, 5'd0, 1'b0));
        pulse_start();
        wait_drain("restart");
        @(negedge clk);
        chk("restart_game_over", {31'd0, game_over}, 32'd0);

        // Async reset while player 1 is in RESOLVE.
        q.push_back(mk(K_GRANT, 1'b0, 5'd0, 5'd0, 1'b0));
        shoot(1'b0, 1);
        q.push_back(mk(K_CLR, 1'b1, 5'd1, 5'd0, 1'b0));
        hitres(1'b1);
        wait_drain("pre_reset");
        q.push_back(mk(K_GRANT, 1'b1, 5'd1, 5'd0, 1'b0));
        shoot(1'b1, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_player", {31'd0, player}, 32'd0);
        chk("async_rst_score0", {27'd0, score0}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        hitres(1'b1);
        @(posedge clk); #1 fire_p0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 fire_p0 = 1'b0;
        @(negedge clk);
        chk("post_rst_score1", {27'd0, score1}, 32'd0);
        chk("post_rst_game_over", {31'd0, game_over}, 32'd0);
        repeat (3) @(negedge clk);

        chk("queue_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
- Battleship turn controller. It sequences the shared 4-bit turn-timer up-counter by driving its clear and enable, and reads its count back.
- Alternates the fire resource between player 0 and player 1. Grants one shot per turn and forfeits the turn on timeout.
- Tallies hits per player and declares a winner.
- Sits between the player input logic, the board/hit-check logic and the turn-timer counter.

Parameters:
- TURN_TICKS, 15, counter value at which a turn times out (1..15; the counter is 4 bits).
- WIN_HITS, 17, hits needed to win (1..31; scores are 5 bits).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a game; sampled only in IDLE or DONE.
- tick  in  1  one-cycle timebase pulse; advances the turn timer.
- fire_p0  in  1  fire request from player 0.
- fire_p1  in  1  fire request from player 1.
- hit_valid  in  1  board logic has resolved the granted shot.
- hit  in  1  resolved shot was a hit; qualified by hit_valid.
- cnt_val  in  4  current turn-timer count.
- cnt_clr  out  1  registered; clears the turn-timer counter.
- cnt_en  out  1  combinational; counter increment enable.
- player  out  1  active player, registered.
- fire_grant  out  1  registered one-cycle pulse; shot accepted for `player`.
- timeout  out  1  registered one-cycle pulse; turn forfeited.
- score0  out  5  player 0 hit count.
- score1  out  5  player 1 hit count.
- game_over  out  1  high in DONE.
- winner  out  1  winning player; valid while game_over=1.

Behaviour:
- Reset (async, any state): state=IDLE, player=0, scores=0, cnt_clr=0, fire_grant=0, timeout=0, game_over=0, winner=0.
- States: IDLE, TURN, RESOLVE, SWAP, DONE.
- IDLE, start=1:
  - next cycle: state=TURN, player=0, score0=score1=0, cnt_clr=1 for exactly that one cycle.
- cnt_en = (state==TURN) & tick & ~cnt_clr. Zero in every other state, so the timer freezes during RESOLVE.
- Active fire is fire_p0 when player=0, fire_p1 when player=1. Inactive player's fire is ignored in all states.
- TURN, evaluated only when cnt_clr=0 (the first cycle after a clear never fires or times out):
  - active fire=1 -> fire_grant=1 next cycle, state=RESOLVE.
  - else cnt_val >= TURN_TICKS -> timeout=1 next cycle, state=SWAP.
  - active fire and timeout condition in the same cycle: fire wins, no timeout pulse.
  - fire held high beyond the grant does not produce a second grant; only one grant per turn.
- RESOLVE:
  - waits indefinitely for hit_valid; hit ignored without hit_valid.
  - hit_valid & hit: score[player] += 1. If the new score == WIN_HITS -> state=DONE, winner=player, game_over=1 next cycle. Otherwise -> SWAP.
  - hit_valid & ~hit: -> SWAP.
  - hit_valid in any other state is ignored.
- SWAP (1 cycle): player toggles, cnt_clr=1 next cycle, state=TURN. Turns always alternate; a hit does not grant an extra turn.
- DONE:
  - holds scores, winner and game_over=1.
  - start=1 -> same action as start in IDLE (scores cleared, player=0, cnt_clr pulse, game_over=0).
- start outside IDLE/DONE is ignored.
- Scores never exceed WIN_HITS, so no wrap.
- Reset mid-turn or mid-RESOLVE aborts immediately to the reset values; any pending hit_valid is discarded.
- fire_grant, timeout and cnt_clr are never high for two consecutive cycles.

Test Plan:
- Reset then start:
  - rst high 2 cycles, then start pulse -> cnt_clr=1 one cycle, player=0, state TURN, scores 0.
  - tick every 4th cycle -> cnt_en pulses track tick.
- Normal shot:
  - player 0, fire_p1=1 -> no grant.
  - fire_p0=1 -> fire_grant one cycle, cnt_en stays 0 while waiting.
  - hit_valid=1, hit=1 -> score0=1, player=1, cnt_clr pulse.
- Timeout:
  - no fire, counter model reaches 15 -> timeout one cycle, player toggles, score unchanged, cnt_clr pulse.
  - fire_p0 in the same cycle cnt_val=15 -> fire_grant, no timeout.
- Win:
  - WIN_HITS=3, player 0 hits on 3 own turns, player 1 misses -> after the third hit_valid&hit: game_over=1, winner=0, score0=3, score1=0.
  - fire inputs then ignored.
- Restart and ignored start:
  - start mid-TURN -> no effect.
  - start in DONE -> scores 0, game_over=0, player=0, cnt_clr pulse.
- Async reset during RESOLVE:
  - rst asserted between clock edges -> outputs reset immediately.
  - hit_valid after rst deasserts -> no score change, state IDLE.
